// File: rtl/scene_pkg.sv
// ---------------------------------------------------------------------------
// scene_pkg
// Shared definitions for the VGA scene sequencer and its layer arbiter.
//   scene_t        : scene encodings (OPEN, SELECT, PLAY, DONE)
//   H_*            : house encodings carried on the 'house' output
//   CNT_W          : width of the frame counter (legal frame counts 1..1023)
//   is_one_hot     : true when exactly one house select bit is set
//   house_encode   : one-hot house select to binary house number
// ---------------------------------------------------------------------------
package scene_pkg;

   localparam int CNT_W = $clog2(1024);

   typedef enum logic [1:0] {
      SC_OPEN   = 2'd0,
      SC_SELECT = 2'd1,
      SC_PLAY   = 2'd2,
      SC_DONE   = 2'd3
   } scene_t;

   localparam logic [1:0] H_GRYF = 2'd0;
   localparam logic [1:0] H_SLYT = 2'd1;
   localparam logic [1:0] H_HUFF = 2'd2;
   localparam logic [1:0] H_RAVN = 2'd3;

   // A value is one-hot when it is non-zero and clearing its lowest set
   // bit leaves nothing behind.
   function automatic logic is_one_hot(input logic [3:0] sel);
      return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
   endfunction

   // Select bits are ordered {ravenclaw, hufflepuff, slytherin, gryffindor},
   // so the bit position is the house number. Only called on one-hot input.
   function automatic logic [1:0] house_encode(input logic [3:0] sel);
      logic [1:0] h;
      case (sel)
         4'b0001: h = H_GRYF;
         4'b0010: h = H_SLYT;
         4'b0100: h = H_HUFF;
         4'b1000: h = H_RAVN;
         default: h = H_GRYF;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/layer_arbiter.sv
// ---------------------------------------------------------------------------
// layer_arbiter
// Picks one palette index per pixel clock from the layer requesters using a
// scene-dependent priority, then registers it for the palette ROM address.
// Ports:
//   iVGA_CLK, iRST_n        pixel clock, async active-low reset
//   scene                   registered scene from the sequencer
//   logo/crest/cursor/box   layer request (_v) and palette index (_idx)
//   bg_idx                  background index, always valid
//   pix_index               arbitrated index, one cycle after the inputs
// ---------------------------------------------------------------------------
module layer_arbiter
   import scene_pkg::*;
#(
   parameter logic [7:0] BG_INDEX = 8'd0
) (
   input  logic       iVGA_CLK,
   input  logic       iRST_n,
   input  scene_t     scene,
   input  logic       logo_v,
   input  logic [7:0] logo_idx,
   input  logic       crest_v,
   input  logic [7:0] crest_idx,
   input  logic       cursor_v,
   input  logic [7:0] cursor_idx,
   input  logic       box_v,
   input  logic [7:0] box_idx,
   input  logic [7:0] bg_idx,
   output logic [7:0] pix_index
);

   logic [7:0] sel_idx;

   // Priority select. The opening screen never shows the game background;
   // it falls back to the fixed BG_INDEX colour instead of bg_idx.
   always_comb begin
      sel_idx = bg_idx;
      case (scene)
         SC_OPEN: begin
            sel_idx = logo_v ? logo_idx : BG_INDEX;
         end
         SC_SELECT: begin
            if (crest_v) sel_idx = crest_idx;
         end
         SC_PLAY: begin
            if (crest_v)       sel_idx = crest_idx;
            else if (cursor_v) sel_idx = cursor_idx;
            else if (box_v)    sel_idx = box_idx;
         end
         SC_DONE: begin
            if (crest_v)    sel_idx = crest_idx;
            else if (box_v) sel_idx = box_idx;
         end
         default: sel_idx = bg_idx;
      endcase
   end

   // Single output register so the ROM address has exactly one driver.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) pix_index <= 8'd0;
      else         pix_index <= sel_idx;
   end

endmodule

// File: rtl/scene_sequencer.sv
// ---------------------------------------------------------------------------
// scene_sequencer
// Frame-synchronous game scene controller: opening logo, house select,
// trace play and result screens, plus the pixel-layer arbiter.
// Ports:
//   iVGA_CLK, iRST_n        pixel clock, async active-low reset
//   vs_n                    vertical sync, active low
//   house_sel               {ravenclaw, hufflepuff, slytherin, gryffindor}
//   trace_done              one-cycle pulse, spell trace completed
//   *_v / *_idx, bg_idx     layer requests and palette indices
//   pix_index               registered arbitrated palette index
//   scene                   current scene encoding
//   house, house_valid      latched house and its valid flag
//   frame_tick              one-cycle pulse on each vs_n falling edge
// ---------------------------------------------------------------------------
module scene_sequencer
   import scene_pkg::*;
#(
   parameter int         LOGO_FRAMES = 180,
   parameter int         DONE_FRAMES = 120,
   parameter logic [7:0] BG_INDEX    = 8'd0
) (
   input  logic       iVGA_CLK,
   input  logic       iRST_n,
   input  logic       vs_n,
   input  logic [3:0] house_sel,
   input  logic       trace_done,
   input  logic       logo_v,
   input  logic [7:0] logo_idx,
   input  logic       crest_v,
   input  logic [7:0] crest_idx,
   input  logic       cursor_v,
   input  logic [7:0] cursor_idx,
   input  logic       box_v,
   input  logic [7:0] box_idx,
   input  logic [7:0] bg_idx,
   output logic [7:0] pix_index,
   output logic [1:0] scene,
   output logic [1:0] house,
   output logic       house_valid,
   output logic       frame_tick
);

   localparam logic [CNT_W-1:0] LOGO_LAST = CNT_W'(LOGO_FRAMES - 1);
   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_FRAMES - 1);

   scene_t           scene_q;
   logic [CNT_W-1:0] frame_cnt;
   logic             done_flag;
   logic             vs_q;
   logic             vs_armed;

   // vs_q resets high, so on its own it would report a falling edge if vs_n
   // is already low when reset lifts. vs_armed holds ticks off until a real
   // high level has been sampled on vs_n.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         vs_q     <= 1'b1;
         vs_armed <= 1'b0;
      end else begin
         vs_q <= vs_n;
         if (vs_n) vs_armed <= 1'b1;
      end
   end

   assign frame_tick = vs_armed & vs_q & ~vs_n;

   // Scene FSM. Every transition and the house latch happen only on a frame
   // tick, so the arbiter never switches layer source in the middle of a
   // frame. The counter is compared before it increments and is cleared on
   // every exit, so it cannot wrap for any legal frame count.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         scene_q     <= SC_OPEN;
         frame_cnt   <= '0;
         done_flag   <= 1'b0;
         house       <= H_GRYF;
         house_valid <= 1'b0;
      end else begin
         case (scene_q)
            SC_OPEN: begin
               if (frame_tick) begin
                  if (frame_cnt == LOGO_LAST) begin
                     scene_q   <= SC_SELECT;
                     frame_cnt <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            SC_SELECT: begin
               if (frame_tick && is_one_hot(house_sel)) begin
                  house       <= house_encode(house_sel);
                  house_valid <= 1'b1;
                  scene_q     <= SC_PLAY;
               end
            end
            SC_PLAY: begin
               // A pulse landing on the tick cycle counts immediately
               // instead of waiting a whole extra frame in the flag.
               if (frame_tick && (done_flag || trace_done)) begin
                  scene_q   <= SC_DONE;
                  done_flag <= 1'b0;
                  frame_cnt <= '0;
               end else if (trace_done) begin
                  done_flag <= 1'b1;
               end
            end
            SC_DONE: begin
               if (frame_tick) begin
                  if (frame_cnt == DONE_LAST) begin
                     scene_q     <= SC_SELECT;
                     house       <= H_GRYF;
                     house_valid <= 1'b0;
                     frame_cnt   <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            default: scene_q <= SC_OPEN;
         endcase
      end
   end

   assign scene = scene_q;

   layer_arbiter #(
      .BG_INDEX (BG_INDEX)
   ) u_layer_arbiter (
      .iVGA_CLK   (iVGA_CLK),
      .iRST_n     (iRST_n),
      .scene      (scene_q),
      .logo_v     (logo_v),
      .logo_idx   (logo_idx),
      .crest_v    (crest_v),
      .crest_idx  (crest_idx),
      .cursor_v   (cursor_v),
      .cursor_idx (cursor_idx),
      .box_v      (box_v),
      .box_idx    (box_idx),
      .bg_idx     (bg_idx),
      .pix_index  (pix_index)
   );

endmodule

// File: tb/tb_scene_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scene_sequencer
// Directed bench for scene_sequencer with short logo/result timeouts so the
// whole game loop fits in a few dozen frames.
// ---------------------------------------------------------------------------
module tb_scene_sequencer;

   logic       iVGA_CLK;
   logic       iRST_n;
   logic       vs_n;
   logic [3:0] house_sel;
   logic       trace_done;
   logic       logo_v;
   logic [7:0] logo_idx;
   logic       crest_v;
   logic [7:0] crest_idx;
   logic       cursor_v;
   logic [7:0] cursor_idx;
   logic       box_v;
   logic [7:0] box_idx;
   logic [7:0] bg_idx;
   logic [7:0] pix_index;
   logic [1:0] scene;
   logic [1:0] house;
   logic       house_valid;
   logic       frame_tick;

   int passCount;
   int checkCount;

   scene_sequencer #(
      .LOGO_FRAMES (3),
      .DONE_FRAMES (2),
      .BG_INDEX    (8'h3C)
   ) dut (
      .iVGA_CLK    (iVGA_CLK),
      .iRST_n      (iRST_n),
      .vs_n        (vs_n),
      .house_sel   (house_sel),
      .trace_done  (trace_done),
      .logo_v      (logo_v),
      .logo_idx    (logo_idx),
      .crest_v     (crest_v),
      .crest_idx   (crest_idx),
      .cursor_v    (cursor_v),
      .cursor_idx  (cursor_idx),
      .box_v       (box_v),
      .box_idx     (box_idx),
      .bg_idx      (bg_idx),
      .pix_index   (pix_index),
      .scene       (scene),
      .house       (house),
      .house_valid (house_valid),
      .frame_tick  (frame_tick)
   );

   // 10 ns pixel clock.
   initial begin
      iVGA_CLK = 1'b0;
      forever #5 iVGA_CLK = ~iVGA_CLK;
   end

   // Safety net in case the directed sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checkCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic cv, input logic [7:0] ci,
                                input logic uv, input logic [7:0] ui,
                                input logic bv, input logic [7:0] bi);
      crest_v    = cv;
      crest_idx  = ci;
      cursor_v   = uv;
      cursor_idx = ui;
      box_v      = bv;
      box_idx    = bi;
   endtask

   // Advance n rising edges and land 1 ns after the last one.
   task automatic waitCycles(input int n);
      repeat (n) @(posedge iVGA_CLK);
      #1;
   endtask

   // One vsync: low for one edge (the tick edge), then high for one edge.
   task automatic pulseVsync();
      vs_n = 1'b0;
      waitCycles(1);
      vs_n = 1'b1;
      waitCycles(1);
   endtask

   initial begin
      passCount  = 0;
      checkCount = 0;
      iRST_n     = 1'b0;
      vs_n       = 1'b1;
      house_sel  = 4'b0000;
      trace_done = 1'b0;
      logo_v     = 1'b1;
      logo_idx   = 8'h21;
      bg_idx     = 8'h05;
      applyStimulus(1'b0, 8'h10, 1'b0, 8'h20, 1'b0, 8'h30);

      // Reset state.
      #12;
      checkOutput("rst_scene", {6'd0, scene}, 8'd0);
      checkOutput("rst_pix", pix_index, 8'h00);
      checkOutput("rst_house_valid", {7'd0, house_valid}, 8'd0);
      checkOutput("rst_tick", {7'd0, frame_tick}, 8'd0);
      iRST_n = 1'b1;
      waitCycles(2);

      // Opening screen: logo shown, then BG_INDEX when the logo drops out.
      checkOutput("open_logo", pix_index, 8'h21);
      logo_v = 1'b0;
      waitCycles(1);
      checkOutput("open_bg_index", pix_index, 8'h3C);
      logo_v = 1'b1;
      waitCycles(1);
      checkOutput("open_logo_again", pix_index, 8'h21);

      pulseVsync();
      checkOutput("open_tick1", {6'd0, scene}, 8'd0);
      pulseVsync();
      checkOutput("open_tick2", {6'd0, scene}, 8'd0);
      vs_n = 1'b0;
      #1;
      checkOutput("tick_pulse", {7'd0, frame_tick}, 8'd1);
      waitCycles(1);
      checkOutput("open_tick3", {6'd0, scene}, 8'd1);
      vs_n = 1'b1;
      waitCycles(1);
      checkOutput("select_logo_ignored", pix_index, 8'h05);
      checkOutput("tick_after_high", {7'd0, frame_tick}, 8'd0);

      // House select: two bits set is rejected, one-hot latches.
      house_sel = 4'b0011;
      pulseVsync();
      checkOutput("sel_multi_scene", {6'd0, scene}, 8'd1);
      checkOutput("sel_multi_valid", {7'd0, house_valid}, 8'd0);
      house_sel = 4'b0100;
      pulseVsync();
      checkOutput("sel_scene", {6'd0, scene}, 8'd2);
      checkOutput("sel_house", {6'd0, house}, 8'd2);
      checkOutput("sel_valid", {7'd0, house_valid}, 8'd1);
      house_sel = 4'b0000;

      // Play priority: crest > cursor > box > bg.
      applyStimulus(1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 8'h30);
      waitCycles(1);
      checkOutput("play_crest", pix_index, 8'h10);
      applyStimulus(1'b0, 8'h10, 1'b1, 8'h20, 1'b1, 8'h30);
      waitCycles(1);
      checkOutput("play_cursor", pix_index, 8'h20);
      applyStimulus(1'b0, 8'h10, 1'b0, 8'h20, 1'b1, 8'h30);
      waitCycles(1);
      checkOutput("play_box", pix_index, 8'h30);
      applyStimulus(1'b0, 8'h10, 1'b0, 8'h20, 1'b0, 8'h30);
      waitCycles(1);
      checkOutput("play_bg", pix_index, 8'h05);

      // Mid-frame trace_done waits for the next tick.
      trace_done = 1'b1;
      waitCycles(1);
      trace_done = 1'b0;
      waitCycles(3);
      checkOutput("trace_wait", {6'd0, scene}, 8'd2);
      pulseVsync();
      checkOutput("trace_to_done", {6'd0, scene}, 8'd3);

      // Result screen ignores the cursor layer.
      applyStimulus(1'b0, 8'h10, 1'b1, 8'h20, 1'b1, 8'h30);
      waitCycles(1);
      checkOutput("done_box_over_cursor", pix_index, 8'h30);
      applyStimulus(1'b0, 8'h10, 1'b0, 8'h20, 1'b0, 8'h30);

      pulseVsync();
      checkOutput("done_hold", {6'd0, scene}, 8'd3);
      pulseVsync();
      checkOutput("done_exit", {6'd0, scene}, 8'd1);
      checkOutput("done_exit_valid", {7'd0, house_valid}, 8'd0);
      checkOutput("done_exit_house", {6'd0, house}, 8'd0);

      // trace_done outside PLAY must not leave a stale flag behind.
      trace_done = 1'b1;
      waitCycles(1);
      trace_done = 1'b0;
      house_sel = 4'b0001;
      pulseVsync();
      checkOutput("relatch_scene", {6'd0, scene}, 8'd2);
      checkOutput("relatch_house", {6'd0, house}, 8'd0);
      checkOutput("relatch_valid", {7'd0, house_valid}, 8'd1);
      house_sel = 4'b0000;
      pulseVsync();
      checkOutput("no_stale_flag", {6'd0, scene}, 8'd2);

      // trace_done coincident with the tick.
      vs_n       = 1'b0;
      trace_done = 1'b1;
      waitCycles(1);
      trace_done = 1'b0;
      vs_n       = 1'b1;
      waitCycles(1);
      checkOutput("trace_coincident", {6'd0, scene}, 8'd3);
      pulseVsync();
      pulseVsync();
      checkOutput("done_exit2", {6'd0, scene}, 8'd1);

      // Back into PLAY as ravenclaw, then async reset mid-frame.
      house_sel = 4'b1000;
      pulseVsync();
      checkOutput("ravn_house", {6'd0, house}, 8'd3);
      house_sel = 4'b0000;
      applyStimulus(1'b1, 8'h10, 1'b0, 8'h20, 1'b0, 8'h30);
      waitCycles(1);
      checkOutput("pre_reset_pix", pix_index, 8'h10);
      #3;
      iRST_n = 1'b0;
      #1;
      checkOutput("async_scene", {6'd0, scene}, 8'd0);
      checkOutput("async_pix", pix_index, 8'h00);
      checkOutput("async_valid", {7'd0, house_valid}, 8'd0);

      // Release with vs_n held low: no tick may appear.
      vs_n = 1'b0;
      #4;
      iRST_n = 1'b1;
      #1;
      checkOutput("release_tick0", {7'd0, frame_tick}, 8'd0);
      for (int i = 0; i < 3; i++) begin
         waitCycles(1);
         checkOutput("release_tick", {7'd0, frame_tick}, 8'd0);
      end
      checkOutput("release_scene", {6'd0, scene}, 8'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
